alu_pipe: RTL and testbench
===========================

Name: alu_pipe

Overview:
- Parametrised, two-stage pipelined successor to the combinational datapath ALU.
- Executes the 16 ARM data-processing opcodes (AND..MVN) on WIDTH-bit operands.
- Keeps an architectural NZCV flag register and uses valid/ready handshakes on both sides.
- Sits between operand fetch/shift and register-file writeback in the execute stage.

Parameters:
- WIDTH, 32, operand/result width in bits (>=8).
- SHW, $clog2(WIDTH), width of the shift-amount field.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  input operation valid.
- in_ready  output  1  alu_pipe can accept an input this cycle.
- in_op  input  4  ARM opcode: 0 AND, 1 EOR, 2 SUB, 3 RSB, 4 ADD, 5 ADC, 6 SBC, 7 RSC, 8 TST, 9 TEQ, A CMP, B CMN, C ORR, D MOV, E BIC, F MVN.
- in_s  input  1  set-flags bit.
- in_a  input  WIDTH  Rn operand.
- in_b  input  WIDTH  operand2 before the optional shift.
- in_sh_type  input  2  shift type: 0 LSL, 1 LSR, 2 ASR, 3 ROR.
- in_sh_amt  input  SHW  shift amount.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts the result.
- out_result  output  WIDTH  operation result.
- out_wr  output  1  result is to be written back; 0 for TST/TEQ/CMP/CMN.
- out_flags  output  4  NZCV value after this operation.
- flags  output  4  current NZCV register.

Behaviour:
- Reset, synchronous: s1_valid=0, out_valid=0, out_result=0, out_wr=0, out_flags=0, flags=0. This applies even mid-stream; in-flight operations are discarded.
- Stage 1 registers op, s, a, b, sh_type and sh_amt on an in_valid && in_ready transfer.
- Stage 2 computes and registers the result. Compute happens on the edge that moves stage 1 into the output register.
- Latency: result visible 2 cycles after input acceptance when there is no backpressure. Throughput is 1 operation per cycle.
- Handshake:
  - out_advance = !out_valid || out_ready.
  - in_ready = !s1_valid || out_advance.
  - Outputs hold stable while out_valid && !out_ready.
  - Simultaneous accept-in and drain-out in one cycle is legal.
- Arithmetic:
  - SUB: a-b. RSB: b-a.
  - ADC: a+b+C. SBC: a-b-!C. RSC: b-a-!C.
  - C for additions = carry-out. C for subtractions = NOT borrow.
  - V = signed overflow of the add/sub actually performed.
- Logical ops:
  - V unchanged.
  - C = shifter carry-out when ALU_SHIFT_EN is defined; otherwise C unchanged.
- Flags:
  - N = result[WIDTH-1]; Z = (result==0).
  - TST/TEQ/CMP/CMN always update flags, ignoring in_s.
  - All other ops update flags only when s=1.
- Flag timing:
  - The flags register updates on the same edge the result is registered.
  - Carry-in C is read from the flags register at compute time, so back-to-back ADDS then ADC uses the fresh carry with no hazard.
  - out_flags equals the new flags value when the op sets flags, otherwise the unchanged value.
- A stalled output does not stall flag ordering: ops compute strictly in acceptance order.

Optional Feature:
- ALU_SHIFT_EN defined: operand2 = shift(in_b, sh_type, sh_amt), computed in stage 2.
  - LSL/LSR/ASR/ROR by 0..WIDTH-1.
  - Amount 0 means no shift, and shifter carry = current C.
  - Otherwise carry = last bit shifted out.
- ALU_SHIFT_EN undefined: operand2 = in_b; sh ports are ignored and unregistered; shifter carry = current C.

Decomposition:
- Package alu_pipe_pkg holds:
  - opcode localparams OP_AND..OP_MVN;
  - flag bit indices FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0;
  - function is_test_op(op).
- One sub-module, alu_shifter (combinational): in_b, type, amt, cin -> shifted value, carry-out. It is instantiated only under ALU_SHIFT_EN.

Test Plan (WIDTH=32):
- ADDS a=FFFFFFFF, b=00000001 -> after 2 cycles out_result=00000000, out_wr=1, out_flags=0110 (Z,C).
- Back-to-back ADDS 0xFFFFFFFF+1 then ADC a=0,b=0 -> second result=00000001 (fresh C used).
- CMP a=5, b=7, in_s=0 -> out_wr=0, flags=1000 (N, borrow so C=0); SUBS 0x80000000-1 -> result 7FFFFFFF, flags=0011 (C,V).
- Backpressure: out_ready=0 for 3 cycles with 3 ops issued -> in_ready drops after 2 are accepted; results later emerge in order, unchanged while stalled.
- Reset asserted with both stages full -> next cycle out_valid=0, flags=0000, in_ready=1; no stale result emerges.
- ALU_SHIFT_EN: MOVS b=00000003, LSR #1 -> result 00000001, C=1. Without the macro, the same op gives result 00000003 and C unchanged.

Source files
------------

// File: rtl/alu_pipe_pkg.sv
// alu_pipe_pkg: shared definitions for the pipelined ARM data-processing ALU.
//   - OP_AND..OP_MVN : 4-bit ARM data-processing opcodes
//   - FLAG_N/Z/C/V   : bit positions inside the 4-bit NZCV vector
//   - is_test_op()   : TST/TEQ/CMP/CMN (always set flags, never write back)
//   - is_logic_op()  : ops whose C comes from the shifter and V is preserved
package alu_pipe_pkg;

  localparam logic [3:0] OP_AND = 4'h0;
  localparam logic [3:0] OP_EOR = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_RSB = 4'h3;
  localparam logic [3:0] OP_ADD = 4'h4;
  localparam logic [3:0] OP_ADC = 4'h5;
  localparam logic [3:0] OP_SBC = 4'h6;
  localparam logic [3:0] OP_RSC = 4'h7;
  localparam logic [3:0] OP_TST = 4'h8;
  localparam logic [3:0] OP_TEQ = 4'h9;
  localparam logic [3:0] OP_CMP = 4'hA;
  localparam logic [3:0] OP_CMN = 4'hB;
  localparam logic [3:0] OP_ORR = 4'hC;
  localparam logic [3:0] OP_MOV = 4'hD;
  localparam logic [3:0] OP_BIC = 4'hE;
  localparam logic [3:0] OP_MVN = 4'hF;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  // Opcodes 8..B are the compare/test group.
  function automatic logic is_test_op(input logic [3:0] op);
    return (op[3:2] == 2'b10);
  endfunction

  function automatic logic is_logic_op(input logic [3:0] op);
    case (op)
      OP_AND, OP_EOR, OP_TST, OP_TEQ,
      OP_ORR, OP_MOV, OP_BIC, OP_MVN: return 1'b1;
      default:                        return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_shifter.sv
// alu_shifter: combinational barrel shifter for ARM operand2.
//   i_b    : value to shift
//   i_type : 0 LSL, 1 LSR, 2 ASR, 3 ROR
//   i_amt  : shift amount 0..WIDTH-1 (0 = pass-through)
//   i_cin  : current C flag, returned as carry when i_amt is 0
//   o_val  : shifted value
//   o_cout : last bit shifted out (or i_cin for a zero amount)
module alu_shifter #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] i_b,
  input  logic [1:0]       i_type,
  input  logic [SHW-1:0]   i_amt,
  input  logic             i_cin,
  output logic [WIDTH-1:0] o_val,
  output logic             o_cout
);

  // One guard bit on the shifted-out side captures the carry directly.
  logic [WIDTH:0]        w_lsl;
  logic [WIDTH:0]        w_lsr;
  logic signed [WIDTH:0] w_asr;
  logic [SHW:0]          w_ramt;
  logic [WIDTH-1:0]      w_ror;

  assign w_lsl  = {1'b0, i_b} << i_amt;
  assign w_lsr  = {i_b, 1'b0} >> i_amt;
  assign w_asr  = $signed({i_b, 1'b0}) >>> i_amt;
  assign w_ramt = (SHW + 1)'(WIDTH) - {1'b0, i_amt};
  assign w_ror  = (i_b >> i_amt) | (i_b << w_ramt);

  always_comb begin
    o_val  = i_b;
    o_cout = i_cin;
    if (i_amt != '0) begin
      case (i_type)
        2'd0: begin o_val = w_lsl[WIDTH-1:0]; o_cout = w_lsl[WIDTH];   end
        2'd1: begin o_val = w_lsr[WIDTH:1];   o_cout = w_lsr[0];       end
        2'd2: begin o_val = w_asr[WIDTH:1];   o_cout = w_asr[0];       end
        default: begin o_val = w_ror;         o_cout = w_ror[WIDTH-1]; end
      endcase
    end
  end

endmodule

// File: rtl/alu_pipe.sv
// alu_pipe: two-stage pipelined ARM data-processing ALU with NZCV register.
// Optional feature macro: ALU_SHIFT_EN (operand2 barrel shift in stage 2).
// Ports:
//   clk, reset                : clock, synchronous active-high reset
//   in_valid/in_ready         : input handshake
//   in_op, in_s, in_a, in_b   : opcode, set-flags, Rn, operand2
//   in_sh_type, in_sh_amt     : operand2 shift (used only with ALU_SHIFT_EN)
//   out_valid/out_ready       : output handshake
//   out_result, out_wr        : result and write-back enable
//   out_flags                 : NZCV after this op
//   flags                     : architectural NZCV register
module alu_pipe
  import alu_pipe_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_op,
  input  logic             in_s,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [1:0]       in_sh_type,
  input  logic [SHW-1:0]   in_sh_amt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_wr,
  output logic [3:0]       out_flags,
  output logic [3:0]       flags
);

  logic             r_vld_p1;
  logic [3:0]       r_op_p1;
  logic             r_s_p1;
  logic [WIDTH-1:0] r_a_p1;
  logic [WIDTH-1:0] r_b_p1;
`ifdef ALU_SHIFT_EN
  logic [1:0]       r_sht_p1;
  logic [SHW-1:0]   r_sha_p1;
`endif

  logic             r_vld_p2;
  logic [WIDTH-1:0] r_result_p2;
  logic             r_wr_p2;
  logic [3:0]       r_oflags_p2;
  logic [3:0]       r_flags;

  logic             w_out_adv;
  logic             w_in_fire;
  logic [WIDTH-1:0] w_op2;
  logic             w_shc;
  logic [WIDTH-1:0] w_x;
  logic [WIDTH-1:0] w_y;
  logic             w_cin;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH-1:0] w_res;
  logic             w_c;
  logic             w_v;
  logic             w_set;
  logic [3:0]       w_flags_nx;

  assign w_out_adv = !r_vld_p2 || out_ready;
  assign in_ready  = !r_vld_p1 || w_out_adv;
  assign w_in_fire = in_valid && in_ready;

  // ---- stage 1: operand capture ----
  always_ff @(posedge clk) begin
    if (w_in_fire) begin
      r_op_p1  <= in_op;
      r_s_p1   <= in_s;
      r_a_p1   <= in_a;
      r_b_p1   <= in_b;
`ifdef ALU_SHIFT_EN
      r_sht_p1 <= in_sh_type;
      r_sha_p1 <= in_sh_amt;
`endif
    end
  end

  // ---- stage 2: operand2 shift, ALU, flags ----
`ifdef ALU_SHIFT_EN
  alu_shifter #(.WIDTH(WIDTH), .SHW(SHW)) u_shifter (
    .i_b    (r_b_p1),
    .i_type (r_sht_p1),
    .i_amt  (r_sha_p1),
    .i_cin  (r_flags[FLAG_C]),
    .o_val  (w_op2),
    .o_cout (w_shc)
  );
`else
  logic w_unused_sh;
  assign w_unused_sh = ^{in_sh_type, in_sh_amt};
  assign w_op2       = r_b_p1;
  assign w_shc       = r_flags[FLAG_C];
`endif

  // All arithmetic ops map onto one adder: subtraction is x + ~y + 1,
  // so the adder carry-out is already the ARM "NOT borrow" C flag.
  always_comb begin
    w_x   = r_a_p1;
    w_y   = w_op2;
    w_cin = 1'b0;
    case (r_op_p1)
      OP_SUB, OP_CMP: begin w_y = ~w_op2; w_cin = 1'b1; end
      OP_RSB:         begin w_x = w_op2; w_y = ~r_a_p1; w_cin = 1'b1; end
      OP_ADC:         begin w_cin = r_flags[FLAG_C]; end
      OP_SBC:         begin w_y = ~w_op2; w_cin = r_flags[FLAG_C]; end
      OP_RSC:         begin w_x = w_op2; w_y = ~r_a_p1; w_cin = r_flags[FLAG_C]; end
      default:        begin end
    endcase
  end

  assign w_sum = {1'b0, w_x} + {1'b0, w_y} + {{WIDTH{1'b0}}, w_cin};

  always_comb begin
    case (r_op_p1)
      OP_AND, OP_TST: w_res = r_a_p1 & w_op2;
      OP_EOR, OP_TEQ: w_res = r_a_p1 ^ w_op2;
      OP_ORR:         w_res = r_a_p1 | w_op2;
      OP_MOV:         w_res = w_op2;
      OP_BIC:         w_res = r_a_p1 & ~w_op2;
      OP_MVN:         w_res = ~w_op2;
      default:        w_res = w_sum[WIDTH-1:0];
    endcase
  end

  // Signed overflow: operands agree in sign but the sum does not.
  always_comb begin
    if (is_logic_op(r_op_p1)) begin
      w_c = w_shc;
      w_v = r_flags[FLAG_V];
    end else begin
      w_c = w_sum[WIDTH];
      w_v = (w_x[WIDTH-1] == w_y[WIDTH-1]) && (w_res[WIDTH-1] != w_x[WIDTH-1]);
    end
  end

  assign w_set      = r_s_p1 || is_test_op(r_op_p1);
  assign w_flags_nx = w_set ? {w_res[WIDTH-1], (w_res == '0), w_c, w_v} : r_flags;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_vld_p1    <= 1'b0;
      r_vld_p2    <= 1'b0;
      r_result_p2 <= '0;
      r_wr_p2     <= 1'b0;
      r_oflags_p2 <= 4'b0000;
      r_flags     <= 4'b0000;
    end else begin
      if (w_in_fire)      r_vld_p1 <= 1'b1;
      else if (w_out_adv) r_vld_p1 <= 1'b0;

      if (w_out_adv) begin
        r_vld_p2 <= r_vld_p1;
        if (r_vld_p1) begin
          r_result_p2 <= w_res;
          r_wr_p2     <= !is_test_op(r_op_p1);
          r_oflags_p2 <= w_flags_nx;
          r_flags     <= w_flags_nx;
        end
      end
    end
  end

  assign out_valid  = r_vld_p2;
  assign out_result = r_result_p2;
  assign out_wr     = r_wr_p2;
  assign out_flags  = r_oflags_p2;
  assign flags      = r_flags;

endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: scoreboard bench for alu_pipe (WIDTH=32).
// Expectations follow ALU_SHIFT_EN when it is defined for the build.
module tb_alu_pipe;
  import alu_pipe_pkg::*;

  localparam int W   = 32;
  localparam int SHW = 5;

  logic           clk = 1'b0;
  logic           reset;
  logic           in_valid;
  logic           in_ready;
  logic [3:0]     in_op;
  logic           in_s;
  logic [W-1:0]   in_a;
  logic [W-1:0]   in_b;
  logic [1:0]     in_sh_type;
  logic [SHW-1:0] in_sh_amt;
  logic           out_valid;
  logic           out_ready;
  logic [W-1:0]   out_result;
  logic           out_wr;
  logic [3:0]     out_flags;
  logic [3:0]     flags;

  alu_pipe #(.WIDTH(W), .SHW(SHW)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_s       (in_s),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_sh_type (in_sh_type),
    .in_sh_amt  (in_sh_amt),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_wr     (out_wr),
    .out_flags  (out_flags),
    .flags      (flags)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] res;
    logic         wr;
    logic [3:0]   fl;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Monitor: every presented output is compared against the queue head,
  // including while stalled; the head is retired on a completed transfer.
  always @(negedge clk) begin
    if (!reset && out_valid) begin
      if (q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_output: got result %h with no pending expectation", out_result);
      end else begin
        check("result",    out_result,     q[0].res);
        check("wr",        {31'b0, out_wr}, {31'b0, q[0].wr});
        check("out_flags", {28'b0, out_flags}, {28'b0, q[0].fl});
        check("flags_reg", {28'b0, flags},     {28'b0, q[0].fl});
        if (out_ready) void'(q.pop_front());
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic issue(input logic [3:0] op, input logic s, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [1:0] sht, input logic [SHW-1:0] sha,
                       input logic [W-1:0] er, input logic ew, input logic [3:0] ef);
    exp_t e;
    bit   ok = 0;
    in_valid   = 1'b1;
    in_op      = op;
    in_s       = s;
    in_a       = a;
    in_b       = b;
    in_sh_type = sht;
    in_sh_amt  = sha;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1; break; end
    end
    if (ok) begin
      e.res = er; e.wr = ew; e.fl = ef;
      q.push_back(e);
    end else begin
      n_checks++;
      $display("FAIL accept_timeout: got in_ready=0 for 50 cycles expected 1");
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && q.size() != 0; i++) @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish within time limit");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_op = '0; in_s = 1'b0; in_a = '0; in_b = '0;
    in_sh_type = '0; in_sh_amt = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    @(negedge clk);
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_in_ready",  {31'b0, in_ready},  32'd1);
    check("rst_flags",     {28'b0, flags},     32'd0);
    check("rst_out_flags", {28'b0, out_flags}, 32'd0);
    check("rst_result",    out_result,         32'd0);
    check("rst_wr",        {31'b0, out_wr},    32'd0);
    @(posedge clk); #1;

    // Lone op: latency of two cycles from presentation.
    issue(OP_MOV, 0, 32'h0, 32'h12345678, 2'd0, 5'd0, 32'h12345678, 1, 4'b0000);
    @(negedge clk);
    check("lat_cycle1", {31'b0, out_valid}, 32'd0);
    @(negedge clk);
    check("lat_cycle2", {31'b0, out_valid}, 32'd1);
    @(posedge clk); #1;

    // Back-to-back stream; flags tracked by hand.
    issue(OP_ADD, 1, 32'hFFFFFFFF, 32'h1, 2'd0, 5'd0, 32'h0,        1, 4'b0110);
    issue(OP_ADC, 0, 32'h0, 32'h0,        2'd0, 5'd0, 32'h1,        1, 4'b0110);
    issue(OP_CMP, 0, 32'd5, 32'd7,        2'd0, 5'd0, 32'hFFFFFFFE, 0, 4'b1000);
    issue(OP_SUB, 1, 32'h80000000, 32'h1, 2'd0, 5'd0, 32'h7FFFFFFF, 1, 4'b0011);
    issue(OP_AND, 1, 32'hF0F0F0F0, 32'h0F0F0F0F, 2'd0, 5'd0, 32'h0, 1, 4'b0111);
    issue(OP_ORR, 0, 32'h1, 32'h2,        2'd0, 5'd0, 32'h3,        1, 4'b0111);
    issue(OP_CMP, 0, 32'd5, 32'd7,        2'd0, 5'd0, 32'hFFFFFFFE, 0, 4'b1000);
`ifdef ALU_SHIFT_EN
    issue(OP_MOV, 1, 32'h0, 32'h3,        2'd1, 5'd1, 32'h1,        1, 4'b0010);
`else
    issue(OP_MOV, 1, 32'h0, 32'h3,        2'd1, 5'd1, 32'h3,        1, 4'b0000);
`endif
    issue(OP_RSB, 1, 32'h1, 32'h0,        2'd0, 5'd0, 32'hFFFFFFFF, 1, 4'b1000);
    issue(OP_TEQ, 0, 32'd5, 32'd5,        2'd0, 5'd0, 32'h0,        0, 4'b0100);
    issue(OP_SBC, 1, 32'd5, 32'd3,        2'd0, 5'd0, 32'h1,        1, 4'b0010);
    issue(OP_RSC, 1, 32'd1, 32'd10,       2'd0, 5'd0, 32'd9,        1, 4'b0010);
    issue(OP_MVN, 1, 32'h0, 32'h0,        2'd0, 5'd0, 32'hFFFFFFFF, 1, 4'b1010);
    issue(OP_BIC, 0, 32'hFF, 32'h0F,      2'd0, 5'd0, 32'hF0,       1, 4'b1010);
`ifdef ALU_SHIFT_EN
    issue(OP_MOV, 1, 32'h0, 32'h80000000, 2'd2, 5'd4, 32'hF8000000, 1, 4'b1000);
    issue(OP_MOV, 1, 32'h0, 32'h00000001, 2'd3, 5'd1, 32'h80000000, 1, 4'b1010);
    issue(OP_MOV, 1, 32'h0, 32'hC0000000, 2'd0, 5'd1, 32'h80000000, 1, 4'b1010);
`else
    issue(OP_MOV, 1, 32'h0, 32'h80000000, 2'd2, 5'd4, 32'h80000000, 1, 4'b1010);
    issue(OP_MOV, 1, 32'h0, 32'h00000001, 2'd3, 5'd1, 32'h00000001, 1, 4'b0010);
    issue(OP_MOV, 1, 32'h0, 32'hC0000000, 2'd0, 5'd1, 32'hC0000000, 1, 4'b1010);
`endif
    drain();

    // Backpressure: three ops against a stalled sink.
    out_ready = 1'b0;
    fork
      begin
        issue(OP_ADD, 0, 32'd1, 32'd2,   2'd0, 5'd0, 32'd3,  1, 4'b1010);
        issue(OP_EOR, 0, 32'hFF, 32'h0F, 2'd0, 5'd0, 32'hF0, 1, 4'b1010);
        issue(OP_SUB, 0, 32'd10, 32'd3,  2'd0, 5'd0, 32'd7,  1, 4'b1010);
      end
      begin
        repeat (3) @(negedge clk);
        check("bp_in_ready_low", {31'b0, in_ready}, 32'd0);
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    drain();

    // Reset with both stages occupied discards the in-flight ops.
    out_ready = 1'b0;
    issue(OP_ADD, 1, 32'hFFFFFFFF, 32'h1, 2'd0, 5'd0, 32'h0, 1, 4'b0110);
    issue(OP_ADD, 1, 32'h1, 32'h1,        2'd0, 5'd0, 32'h2, 1, 4'b0000);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    q.delete();
    @(negedge clk);
    check("mid_rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("mid_rst_flags",     {28'b0, flags},     32'd0);
    check("mid_rst_in_ready",  {31'b0, in_ready},  32'd1);
    @(posedge clk); #1;
    out_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    issue(OP_ADD, 1, 32'd2, 32'd2, 2'd0, 5'd0, 32'd4, 1, 4'b0000);
    drain();

    check("queue_drained", q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
